// File: rtl/lockstep_fault_manager.sv
// ----------------------------------------------------------------------------
// lockstep_fault_manager
//
// Purpose:
//   Watches the registered verdict of the master/shadow lockstep comparator.
//   Short disagreements are filtered and counted as transients. A disagreement
//   that persists is treated as a confirmed fault: both cores get a reset
//   request for a recovery retry, and the block then waits for them to report
//   ready again. When the retry budget is used up, or the cores never come
//   back, the block parks in a sticky FAILSAFE state. Only a software clear
//   leaves FAILSAFE.
//
// Parameters:
//   CONFIRM_N   consecutive mismatch cycles that confirm a fault (1..15)
//   RST_CYCLES  cycles core_rst_req is held per recovery (1..255)
//   ACK_TIMEOUT maximum wait for core_ready after reset release (1..65535)
//   MAX_RETRIES recoveries allowed before going fatal (1..15)
//
// Ports:
//   clk            system clock
//   reset          synchronous active-high reset
//   match          comparator match flag
//   mismatch       comparator mismatch flag
//   core_ready     master and shadow cores out of reset and running
//   clr_fault      software clear, only acts in FAILSAFE
//   core_rst_req   reset request to both cores
//   fault_irq      one-cycle pulse on each confirmed fault
//   fault_fatal    sticky fatal indication
//   state          current state (RUN=0 CONFIRM=1 RECOVER=2 WAIT_ACK=3
//                  FAILSAFE=4)
//   retry_cnt      recoveries performed since reset or clear
//   transient_cnt  filtered transients, saturating at 255
//
// Optional feature (macro LOCKSTEP_ERR_LOG_EN):
//   master_output, shadow_output  32-bit operands from the two cores
//   err_master, err_shadow        operands captured at the first fault event
//   err_valid                     the capture holds valid data
// ----------------------------------------------------------------------------
module lockstep_fault_manager #(
    parameter int unsigned CONFIRM_N   = 3,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned MAX_RETRIES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        match,
    input  logic        mismatch,
    input  logic        core_ready,
    input  logic        clr_fault,
`ifdef LOCKSTEP_ERR_LOG_EN
    input  logic [31:0] master_output,
    input  logic [31:0] shadow_output,
    output logic [31:0] err_master,
    output logic [31:0] err_shadow,
    output logic        err_valid,
`endif
    output logic        core_rst_req,
    output logic        fault_irq,
    output logic        fault_fatal,
    output logic [2:0]  state,
    output logic [3:0]  retry_cnt,
    output logic [7:0]  transient_cnt
);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_CONFIRM  = 3'd1,
        ST_RECOVER  = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_FAILSAFE = 3'd4
    } state_t;

    localparam logic [4:0]  CONFIRM_LAST = 5'(CONFIRM_N);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);
    localparam logic [15:0] RST_LOAD     = 16'(RST_CYCLES);
    localparam logic [15:0] ACK_LOAD     = 16'(ACK_TIMEOUT);

    state_t      cur_state;
    logic [3:0]  cnt;
    logic [15:0] timer;
    logic        ev;
    logic        confirm;

    // Both flags 0 or both 1 is an illegal comparator encoding and is treated
    // as a disagreement, so a stuck or broken comparator cannot hide a fault.
    assign ev = mismatch | ~match;

    // A fault is confirmed either on the very first event when no filtering
    // is configured, or when the event streak in CONFIRM reaches CONFIRM_N.
    always_comb begin
        confirm = 1'b0;
        if (ev) begin
            if (cur_state == ST_RUN && CONFIRM_N == 1)
                confirm = 1'b1;
            else if (cur_state == ST_CONFIRM && ({1'b0, cnt} + 5'd1) == CONFIRM_LAST)
                confirm = 1'b1;
        end
    end

    assign state = cur_state;

    // Main fault-handling FSM. All outputs are registered here so that the
    // reset and interrupt logic downstream never sees combinational glitches.
    // The single timer is shared: it counts the reset pulse in RECOVER and
    // then the acknowledge window in WAIT_ACK.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state     <= ST_RUN;
            cnt           <= 4'd0;
            timer         <= 16'd0;
            core_rst_req  <= 1'b0;
            fault_irq     <= 1'b0;
            fault_fatal   <= 1'b0;
            retry_cnt     <= 4'd0;
            transient_cnt <= 8'd0;
        end else begin
            fault_irq <= 1'b0;
            if (confirm) begin
                fault_irq    <= 1'b1;
                core_rst_req <= 1'b1;
                if (retry_cnt == RETRY_LIMIT) begin
                    cur_state   <= ST_FAILSAFE;
                    fault_fatal <= 1'b1;
                end else begin
                    cur_state <= ST_RECOVER;
                    retry_cnt <= retry_cnt + 4'd1;
                    timer     <= RST_LOAD;
                end
            end else begin
                case (cur_state)
                    ST_RUN: begin
                        if (ev) begin
                            cur_state <= ST_CONFIRM;
                            cnt       <= 4'd1;
                        end
                    end
                    ST_CONFIRM: begin
                        if (ev) begin
                            cnt <= cnt + 4'd1;
                        end else begin
                            cur_state <= ST_RUN;
                            if (transient_cnt != 8'hFF)
                                transient_cnt <= transient_cnt + 8'd1;
                        end
                    end
                    ST_RECOVER: begin
                        if (timer == 16'd1) begin
                            cur_state    <= ST_WAIT_ACK;
                            core_rst_req <= 1'b0;
                            timer        <= ACK_LOAD;
                        end else begin
                            timer <= timer - 16'd1;
                        end
                    end
                    ST_WAIT_ACK: begin
                        // core_ready beats a coinciding timeout.
                        if (core_ready) begin
                            cur_state <= ST_RUN;
                        end else if (timer == 16'd1) begin
                            cur_state    <= ST_FAILSAFE;
                            fault_fatal  <= 1'b1;
                            core_rst_req <= 1'b1;
                        end else begin
                            timer <= timer - 16'd1;
                        end
                    end
                    ST_FAILSAFE: begin
                        if (clr_fault) begin
                            cur_state     <= ST_RUN;
                            fault_fatal   <= 1'b0;
                            core_rst_req  <= 1'b0;
                            retry_cnt     <= 4'd0;
                            transient_cnt <= 8'd0;
                        end
                    end
                    default: begin
                        cur_state <= ST_RUN;
                    end
                endcase
            end
        end
    end

`ifdef LOCKSTEP_ERR_LOG_EN
    // First-fault log: the operands seen on the first event in RUN are kept
    // until software clears FAILSAFE, so later faults cannot overwrite the
    // evidence of the original divergence.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_master <= 32'd0;
            err_shadow <= 32'd0;
            err_valid  <= 1'b0;
        end else if (cur_state == ST_FAILSAFE && clr_fault) begin
            err_master <= 32'd0;
            err_shadow <= 32'd0;
            err_valid  <= 1'b0;
        end else if (cur_state == ST_RUN && ev && !err_valid) begin
            err_master <= master_output;
            err_shadow <= shadow_output;
            err_valid  <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lockstep_fault_manager.sv
// ----------------------------------------------------------------------------
// tb_lockstep_fault_manager
//
// Self-checking bench for lockstep_fault_manager. A behavioural model tracks
// the block as a mode number plus plain counters (event streak, reset cycles
// left, acknowledge cycles elapsed) and derives the reset request and fatal
// flag from the mode. Directed scenarios cover the main behaviours, then a
// long randomized run stresses the block with varying event densities.
// ----------------------------------------------------------------------------
module tb_lockstep_fault_manager;

    localparam int C_N   = 3;
    localparam int R_CYC = 4;
    localparam int A_TO  = 8;
    localparam int M_RET = 2;

    logic        clk;
    logic        reset;
    logic        match;
    logic        mismatch;
    logic        core_ready;
    logic        clr_fault;
    logic        core_rst_req;
    logic        fault_irq;
    logic        fault_fatal;
    logic [2:0]  state;
    logic [3:0]  retry_cnt;
    logic [7:0]  transient_cnt;
`ifdef LOCKSTEP_ERR_LOG_EN
    logic [31:0] master_output;
    logic [31:0] shadow_output;
    logic [31:0] err_master;
    logic [31:0] err_shadow;
    logic        err_valid;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int irq_seen     = 0;

    // Reference model state
    int m_mode;
    int m_streak;
    int m_rst_left;
    int m_ack_elapsed;
    int m_retry;
    int m_trans;
    int m_irq;
`ifdef LOCKSTEP_ERR_LOG_EN
    logic [31:0] m_err_master;
    logic [31:0] m_err_shadow;
    int          m_err_valid;
`endif

    lockstep_fault_manager #(
        .CONFIRM_N   (C_N),
        .RST_CYCLES  (R_CYC),
        .ACK_TIMEOUT (A_TO),
        .MAX_RETRIES (M_RET)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .match         (match),
        .mismatch      (mismatch),
        .core_ready    (core_ready),
        .clr_fault     (clr_fault),
`ifdef LOCKSTEP_ERR_LOG_EN
        .master_output (master_output),
        .shadow_output (shadow_output),
        .err_master    (err_master),
        .err_shadow    (err_shadow),
        .err_valid     (err_valid),
`endif
        .core_rst_req  (core_rst_req),
        .fault_irq     (fault_irq),
        .fault_fatal   (fault_fatal),
        .state         (state),
        .retry_cnt     (retry_cnt),
        .transient_cnt (transient_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelConfirm();
        m_irq = 1;
        if (m_retry == M_RET) begin
            m_mode = 4;
        end else begin
            m_retry++;
            m_mode     = 2;
            m_rst_left = R_CYC;
        end
    endtask

    // Advances the model by one clock edge with the inputs that edge sampled.
    task automatic modelStep(input logic r, input logic m, input logic mm,
                             input logic rdy, input logic clr);
        bit ev;
        ev = mm | ~m;
        if (r) begin
            m_mode = 0; m_streak = 0; m_retry = 0; m_trans = 0; m_irq = 0;
`ifdef LOCKSTEP_ERR_LOG_EN
            m_err_master = 0; m_err_shadow = 0; m_err_valid = 0;
`endif
            return;
        end
`ifdef LOCKSTEP_ERR_LOG_EN
        if (m_mode == 4 && clr) begin
            m_err_master = 0; m_err_shadow = 0; m_err_valid = 0;
        end else if (m_mode == 0 && ev && m_err_valid == 0) begin
            m_err_master = master_output; m_err_shadow = shadow_output; m_err_valid = 1;
        end
`endif
        m_irq = 0;
        case (m_mode)
            0: if (ev) begin
                   m_streak = 1;
                   if (m_streak >= C_N) modelConfirm();
                   else m_mode = 1;
               end
            1: if (ev) begin
                   m_streak++;
                   if (m_streak >= C_N) modelConfirm();
               end else begin
                   m_mode  = 0;
                   m_trans = (m_trans < 255) ? m_trans + 1 : 255;
               end
            2: begin
                   m_rst_left--;
                   if (m_rst_left == 0) begin
                       m_mode        = 3;
                       m_ack_elapsed = 0;
                   end
               end
            3: begin
                   m_ack_elapsed++;
                   if (rdy) m_mode = 0;
                   else if (m_ack_elapsed == A_TO) m_mode = 4;
               end
            4: if (clr) begin
                   m_mode = 0; m_retry = 0; m_trans = 0;
               end
            default: m_mode = 0;
        endcase
    endtask

    task automatic checkAll();
        checkOutput("state", 32'(state), 32'(m_mode));
        checkOutput("core_rst_req", 32'(core_rst_req), 32'((m_mode == 2 || m_mode == 4) ? 1 : 0));
        checkOutput("fault_fatal", 32'(fault_fatal), 32'((m_mode == 4) ? 1 : 0));
        checkOutput("fault_irq", 32'(fault_irq), 32'(m_irq));
        checkOutput("retry_cnt", 32'(retry_cnt), 32'(m_retry));
        checkOutput("transient_cnt", 32'(transient_cnt), 32'(m_trans));
`ifdef LOCKSTEP_ERR_LOG_EN
        checkOutput("err_valid", 32'(err_valid), 32'(m_err_valid));
        checkOutput("err_master", err_master, m_err_master);
        checkOutput("err_shadow", err_shadow, m_err_shadow);
`endif
    endtask

    // Drives one cycle of inputs, clocks the DUT and the model, then checks.
    task automatic applyStimulus(input logic r, input logic m, input logic mm,
                                 input logic rdy, input logic clr);
        reset = r; match = m; mismatch = mm; core_ready = rdy; clr_fault = clr;
        @(posedge clk);
        modelStep(r, m, mm, rdy, clr);
        #1;
        if (fault_irq === 1'b1) irq_seen++;
        checkAll();
    endtask

    // Shorthands: a good cycle, an event cycle, and a fault of C_N events.
    task automatic good(input logic rdy);
        applyStimulus(1'b0, 1'b1, 1'b0, rdy, 1'b0);
    endtask

    task automatic bad();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic recoverCycle();
        for (int i = 0; i < C_N; i++) bad();
        for (int i = 0; i < R_CYC; i++) good(1'b1);
        good(1'b0);
        good(1'b1);
    endtask

    initial begin
        int ev_pct;
        int rdy_pct;
        int sel;
        logic mm_r;
        logic m_r;
`ifdef LOCKSTEP_ERR_LOG_EN
        master_output = 32'd0;
        shadow_output = 32'd0;
`endif
        reset = 1'b1; match = 1'b1; mismatch = 1'b0; core_ready = 1'b0; clr_fault = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_state", 32'(state), 32'd0);

        // Transient: two events then a match
        bad(); bad(); good(1'b0);
        checkOutput("transient_count", 32'(transient_cnt), 32'd1);
        checkOutput("transient_no_irq", 32'(irq_seen), 32'd0);

        // Confirmed recovery with ready in WAIT_ACK cycle 2
        recoverCycle();
        checkOutput("recovery_retry", 32'(retry_cnt), 32'd1);
        checkOutput("recovery_irq", 32'(irq_seen), 32'd1);

        // Retry exhaustion: second recovery, third fault goes fatal
        recoverCycle();
        for (int i = 0; i < C_N; i++) bad();
        checkOutput("exhaust_state", 32'(state), 32'd4);
        checkOutput("exhaust_fatal", 32'(fault_fatal), 32'd1);
        checkOutput("exhaust_irqs", 32'(irq_seen), 32'd3);
        good(1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Ack timeout then software clear
        for (int i = 0; i < C_N; i++) bad();
        for (int i = 0; i < R_CYC; i++) good(1'b0);
        for (int i = 0; i < A_TO; i++) good(1'b0);
        checkOutput("timeout_state", 32'(state), 32'd4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("clear_retry", 32'(retry_cnt), 32'd0);
        checkOutput("clear_fatal", 32'(fault_fatal), 32'd0);

        // Both flags low counts as an event
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("encoding_00", 32'(state), 32'd1);
        bad(); bad();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_in_recover_req", 32'(core_rst_req), 32'd0);
        checkOutput("reset_in_recover_state", 32'(state), 32'd0);

`ifdef LOCKSTEP_ERR_LOG_EN
        master_output = 32'hDEADBEEF; shadow_output = 32'hDEADBEEE;
        bad();
        master_output = 32'h12345678; shadow_output = 32'h87654321;
        bad(); bad();
        for (int i = 0; i < R_CYC; i++) good(1'b0);
        good(1'b1);
        bad();
        checkOutput("log_master", err_master, 32'hDEADBEEF);
        checkOutput("log_shadow", err_shadow, 32'hDEADBEEE);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        // Randomized run with shifting event and ready densities
        ev_pct = 5; rdy_pct = 30;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 40 == 0) begin
                sel = int'($urandom_range(0, 2));
                ev_pct = (sel == 0) ? 5 : (sel == 1) ? 40 : 85;
                sel = int'($urandom_range(0, 2));
                rdy_pct = (sel == 0) ? 0 : (sel == 1) ? 30 : 80;
            end
            if (int'($urandom_range(0, 99)) < ev_pct) begin
                sel = int'($urandom_range(0, 2));
                m_r  = (sel == 2);
                mm_r = (sel != 0);
            end else begin
                m_r = 1'b1; mm_r = 1'b0;
            end
`ifdef LOCKSTEP_ERR_LOG_EN
            master_output = $urandom;
            shadow_output = $urandom;
`endif
            applyStimulus(($urandom_range(0, 399) == 0),
                          m_r, mm_r,
                          (int'($urandom_range(0, 99)) < rdy_pct),
                          ($urandom_range(0, 99) < 15));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lockstep_fault_manager.md
# lockstep_fault_manager

Consumes the registered match/mismatch verdict of the master/shadow lockstep comparator and decides what to do about it. It filters transient disagreements, requests a core reset for a recovery retry when a mismatch persists, waits for the cores to come back, and escalates to a sticky fatal fault after too many retries. It sits between the comparator and the MPSoC reset and interrupt logic.

## Interface

- CONFIRM_N, 3: consecutive mismatch cycles that confirm a fault; legal range 1..15.
- RST_CYCLES, 4: cycles `core_rst_req` is held per recovery; legal range 1..255.
- ACK_TIMEOUT, 64: maximum wait for `core_ready` after reset release; legal range 1..65535.
- MAX_RETRIES, 2: recoveries allowed before fatal; legal range 1..15.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- match  in  1  comparator match flag.
- mismatch  in  1  comparator mismatch flag.
- core_ready  in  1  master and shadow cores out of reset and running.
- clr_fault  in  1  software clear; acts only in FAILSAFE.
- core_rst_req  out  1  reset request to both cores.
- fault_irq  out  1  one-cycle pulse on each confirmed fault.
- fault_fatal  out  1  sticky fatal indication.
- state  out  3  current state encoding.
- retry_cnt  out  4  recoveries performed.
- transient_cnt  out  8  filtered transients, saturating at 255.

## Operation

- Fault event `ev` = `mismatch | ~match`. An inconsistent flag encoding (both 0 or both 1) counts as an event.
- State encodings: RUN=0, CONFIRM=1, RECOVER=2, WAIT_ACK=3, FAILSAFE=4.
- RUN
  - `ev` with CONFIRM_N>1: go to CONFIRM and load `cnt`=1.
  - `ev` with CONFIRM_N=1: the fault is confirmed immediately.
- CONFIRM
  - `ev` and `cnt+1`==CONFIRM_N: fault confirmed.
  - `ev` otherwise: increment `cnt`.
  - No `ev`: return to RUN and increment `transient_cnt` (saturating).
- Fault confirmed
  - If `retry_cnt`==MAX_RETRIES: go to FAILSAFE.
  - Otherwise: go to RECOVER, increment `retry_cnt`, and load the timer with RST_CYCLES.
  - In both cases `fault_irq` pulses for one cycle.
- RECOVER
  - `core_rst_req`=1 and `ev` is ignored.
  - When the timer expires, go to WAIT_ACK and load the timer with ACK_TIMEOUT.
- WAIT_ACK
  - `ev` is ignored.
  - `core_ready`=1: go to RUN.
  - Timer expires without `core_ready`: go to FAILSAFE. No `fault_irq` pulse on this transition.
- FAILSAFE
  - `fault_fatal`=1 and `core_rst_req`=1; all inputs ignored except `clr_fault`.
  - `clr_fault`: go to RUN and clear `retry_cnt` and `transient_cnt`.
- `retry_cnt` is cleared only by reset or `clr_fault`.
- Simultaneous events
  - `core_ready` in the final RECOVER cycle is ignored; only WAIT_ACK samples it.
  - `core_ready` and timeout in the same WAIT_ACK cycle: `core_ready` wins.
  - `clr_fault` outside FAILSAFE has no effect.

## Timing

- All outputs are registered.
- Reset values:
  - `state`=RUN (0)
  - `core_rst_req`=0, `fault_irq`=0, `fault_fatal`=0
  - `retry_cnt`=0, `transient_cnt`=0
- Reset mid-operation (any state) returns to these values at the next edge. No pending request survives reset.
- `ev` sampled at edge e0 in RUN: `state` is CONFIRM after e0. With CONFIRM_N=3 and `ev` at e0, e1, e2: RECOVER after e2, with `fault_irq` and `core_rst_req` first high in the cycle following e2.
- `core_rst_req` is high for exactly RST_CYCLES cycles per recovery, then drops when the block enters WAIT_ACK.
- `core_ready` sampled high at WAIT_ACK cycle k (1-based): RUN after that edge. If `core_ready` is never high, FAILSAFE follows after ACK_TIMEOUT WAIT_ACK cycles.
- `ev` in the cycle the block returns to RUN is acted on normally at the next edge.

## Configuration

- Macro: `LOCKSTEP_ERR_LOG_EN`.
- Defined:
  - Adds inputs `master_output` and `shadow_output` (32 bits each) and outputs `err_master` and `err_shadow` (32 bits each, reset 0) and `err_valid` (1 bit, reset 0).
  - On the edge where RUN sees `ev` with `err_valid`=0, both operand values are captured and `err_valid` is set.
  - Later faults do not overwrite the capture (first-fault log).
  - `clr_fault` in FAILSAFE clears all three log outputs.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

## Test plan

- Transient: CONFIRM_N=3, `ev` for 2 cycles then match → back to RUN, `transient_cnt`=1, no `fault_irq`, `core_rst_req` stays 0.
- Confirmed recovery: `ev` for 3 cycles → `fault_irq` 1-cycle pulse, `core_rst_req` high for 4 cycles, `core_ready` on WAIT_ACK cycle 2 → RUN, `retry_cnt`=1.
- Retry exhaustion: MAX_RETRIES=2, three confirmed faults each recovered → third goes straight to FAILSAFE, `fault_fatal`=1, `state`=4, three `fault_irq` pulses total.
- Ack timeout: ACK_TIMEOUT=8, `core_ready` held 0 → FAILSAFE after 8 WAIT_ACK cycles; then `clr_fault` → RUN, `retry_cnt`=0, `fault_fatal`=0.
- Encoding and reset: match=0 and mismatch=0 treated as `ev`; reset asserted during RECOVER → next cycle `core_rst_req`=0 and `state`=RUN.
- With `LOCKSTEP_ERR_LOG_EN`: master 0xDEADBEEF, shadow 0xDEADBEEE on the first `ev` → captured and `err_valid`=1; a second fault with other values leaves the log unchanged.
